// File: rtl/bcd_digit_counter_pkg.sv
// Shared constants and the BCD step helper for the single-digit BCD counter.
package bcd_digit_counter_pkg;

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam int DEF_DIV   = 4;
  localparam int DEF_DIV_W = 27;

  typedef struct packed {
    logic [3:0] value;
    logic       wrap;
  } bcd_step_t;

  // One count step in the requested direction; wrap flags 9->0 / 0->9.
  function automatic bcd_step_t bcd_step(input logic [3:0] n, input logic up);
    bcd_step_t s;
    s.wrap  = 1'b0;
    s.value = n;
    if (up) begin
      if (n >= BCD_MAX) begin
        s.value = BCD_MIN;
        s.wrap  = 1'b1;
      end else begin
        s.value = n + 4'd1;
      end
    end else begin
      if (n == BCD_MIN) begin
        s.value = BCD_MAX;
        s.wrap  = 1'b1;
      end else begin
        s.value = n - 4'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit_counter_prescaler.sv
// Clock prescaler: counts 0..DIV-1 while enabled, pulses tick on the last count.
module bcd_prescaler #(
  parameter int DIV   = 4,
  parameter int DIV_W = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == DIV_M1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_d = cnt_q + DIV_W'(1);
    if (!en || clr || tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_digit_counter.sv
// Single-digit BCD up/down counter with prescaler, start/stop FSM and load.
// Optional macro BCD_AUTOSTOP_EN: stop on landing at the terminal value instead of free-running.
module bcd_digit_counter
  import bcd_digit_counter_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       carry,
  output logic       running,
  output logic       load_err
);

  logic [0:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       carry_q, carry_d;
  logic       load_err_q, load_err_d;
  logic       presc_clr;
  logic       tick;
  bcd_step_t  nxt;

  bcd_prescaler #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Priority: load > stop > start > tick. A start while running falls through to tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    presc_clr  = 1'b0;
    nxt        = bcd_step(count_q, up_dn);
    if (load) begin
      if (load_val <= BCD_MAX) begin
        count_d   = load_val;
        presc_clr = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      state_d   = ST_STOP;
      presc_clr = 1'b1;
    end else if (start && (state_q == ST_STOP)) begin
      state_d = ST_RUN;
    end else if (tick) begin
      count_d = nxt.value;
      carry_d = nxt.wrap;
`ifdef BCD_AUTOSTOP_EN
      if (nxt.value == (up_dn ? BCD_MAX : BCD_MIN)) begin
        carry_d = 1'b1;
        state_d = ST_STOP;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      count_q    <= BCD_MIN;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q0       = count_q[0];
  assign Q1       = count_q[1];
  assign Q2       = count_q[2];
  assign Q3       = count_q[3];
  assign carry    = carry_q;
  assign running  = state_q[0];
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Self-checking bench for bcd_digit_counter (DIV=4); honours BCD_AUTOSTOP_EN.
module tb_bcd_digit_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       Q0, Q1, Q2, Q3, carry, running, load_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       start;
    bit       stop;
    bit       up_dn;
    bit       load;
    bit [3:0] load_val;
    bit [3:0] q;
    bit       carry;
    bit       running;
    bit       load_err;
  } vec_t;

  typedef struct {
    bit [3:0] q;
    bit       carry;
    bit       running;
    bit       load_err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int exp_q   = 0;
  bit exp_run = 1'b0;

  bcd_digit_counter #(
    .DIV   (4),
    .DIV_W (27)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q2       (Q2),
    .Q3       (Q3),
    .carry    (carry),
    .running  (running),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit st, input bit sp, input bit ud, input bit ld,
                         input bit [3:0] lv, input bit [3:0] q, input bit cy,
                         input bit rn, input bit le);
    vec_t v;
    v.start = st; v.stop = sp; v.up_dn = ud; v.load = ld; v.load_val = lv;
    v.q = q; v.carry = cy; v.running = rn; v.load_err = le;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input bit ud);
    for (int i = 0; i < n; i++) add_vec(0, 0, ud, 0, 4'd0, 4'(exp_q), 0, exp_run, 0);
  endtask

  task automatic add_load(input int val, input bit ud);
    bit ok = (val <= 9);
    if (ok) exp_q = val;
    add_vec(0, 0, ud, 1, 4'(val), 4'(exp_q), 0, exp_run, !ok);
  endtask

  task automatic add_start(input bit ud);
    exp_run = 1'b1;
    add_vec(1, 0, ud, 0, 4'd0, 4'(exp_q), 0, 1, 0);
  endtask

  task automatic add_stop(input bit ud);
    exp_run = 1'b0;
    add_vec(0, 1, ud, 0, 4'd0, 4'(exp_q), 0, 0, 0);
  endtask

  // n full prescaler periods: three quiet cycles then the stepping cycle.
  task automatic add_steps(input int n, input bit ud);
    int nq;
    bit cy;
    for (int s = 0; s < n; s++) begin
      add_idle(3, ud);
      nq = ud ? (exp_q + 1) % 10 : (exp_q + 9) % 10;
      cy = ud ? (exp_q == 9) : (exp_q == 0);
`ifdef BCD_AUTOSTOP_EN
      if (nq == (ud ? 9 : 0)) begin
        cy = 1'b1;
        exp_run = 1'b0;
      end
`endif
      exp_q = nq;
      add_vec(0, 0, ud, 0, 4'd0, 4'(exp_q), cy, exp_run, 0);
    end
  endtask

  initial begin
    // Reset values before any clock edge.
    #2;
    check("reset_q", {Q3, Q2, Q1, Q0}, 0);
    check("reset_running", running, 0);
    check("reset_carry", carry, 0);
    check("reset_load_err", load_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Common: stop on a tick cycle, bad load, start+stop together.
    add_load(2, 1);
    add_start(1);
    add_steps(1, 1);
    add_idle(3, 1);
    add_stop(1);
    add_idle(2, 1);
    add_load(12, 1);
    add_idle(1, 1);
    add_vec(1, 1, 1, 0, 4'd0, 4'(exp_q), 0, 0, 0);
    add_idle(5, 1);

`ifdef BCD_AUTOSTOP_EN
    add_load(7, 1);
    add_start(1);
    add_steps(2, 1);
    add_idle(4, 1);
    add_start(1);
    add_steps(1, 1);
    add_stop(1);
    add_load(1, 0);
    add_start(0);
    add_steps(1, 0);
    add_idle(4, 0);
`else
    add_load(0, 1);
    add_start(1);
    add_steps(10, 1);
    add_stop(1);
    add_load(3, 0);
    add_start(0);
    add_steps(4, 0);
    add_idle(1, 0);
    add_load(7, 0);
    add_steps(1, 0);
    add_stop(0);
`endif

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      start    = vecs[i].start;
      stop     = vecs[i].stop;
      up_dn    = vecs[i].up_dn;
      load     = vecs[i].load;
      load_val = vecs[i].load_val;
      e.q = vecs[i].q; e.carry = vecs[i].carry;
      e.running = vecs[i].running; e.load_err = vecs[i].load_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d_q", i), {Q3, Q2, Q1, Q0}, e.q);
      check($sformatf("v%0d_carry", i), carry, e.carry);
      check($sformatf("v%0d_running", i), running, e.running);
      check($sformatf("v%0d_load_err", i), load_err, e.load_err);
    end

    // Asynchronous reset mid-count at 6, checked before the next clock edge.
    @(negedge clk);
    start = 0; stop = 0; load = 1; load_val = 4'd6; up_dn = 1;
    @(negedge clk);
    load = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("pre_rst_q", {Q3, Q2, Q1, Q0}, 6);
    check("pre_rst_running", running, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", {Q3, Q2, Q1, Q0}, 0);
    check("async_rst_running", running, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_q_hold", {Q3, Q2, Q1, Q0}, 0);
    check("post_rst_running", running, 0);
    check("scoreboard_empty", 8'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
